// File: rtl/updown_mod_counter_pkg.sv
// Shared direction encodings and the load clamp used by the updown_mod_counter slice.
// Load clamp works at 33 bits so a 32-bit counter's MODULUS of 2**32 still fits.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [32:0] clamp_to_mod(input logic [32:0] value, input logic [32:0] modulus);
    return (value >= modulus) ? (modulus - 33'd1) : value;
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of one up/down modulo counter; master drives controls, slave is the counter.
// q and wrap are registered, tc is combinational from q, en and up_dn.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap
  );
endinterface

// File: rtl/updown_mod_counter_next.sv
// Combinational next-state for the modulo counter: next q, wrap_next and terminal count, zero latency.
// Optional COUNTER_SAT_EN: saturate at the range ends instead of wrapping; wrap then never fires.
module counter_next #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_wrap_next,
  output logic             o_tc
);
  import counter_pkg::*;

  // MODULUS == 2**WIDTH makes MAX_Q all ones, so the +1 below wraps naturally at WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_load_clamped = WIDTH'(clamp_to_mod(33'(i_load_val), 33'(MODULUS)));
  assign w_at_max       = (i_q == MAX_Q);
  assign w_at_zero      = (i_q == '0);

  assign o_tc = i_en & (((i_up_dn == DIR_UP) & w_at_max) | ((i_up_dn == DIR_DOWN) & w_at_zero));

  always_comb begin
    o_q_next    = i_q;
    o_wrap_next = 1'b0;
    if (i_load) begin
      o_q_next = w_load_clamped;
    end else if (i_en) begin
      if (i_up_dn == DIR_UP) begin
        if (w_at_max) begin
`ifdef COUNTER_SAT_EN
          o_q_next    = MAX_Q;
`else
          o_q_next    = '0;
          o_wrap_next = 1'b1;
`endif
        end else begin
          o_q_next = i_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef COUNTER_SAT_EN
          o_q_next    = '0;
`else
          o_q_next    = MAX_Q;
          o_wrap_next = 1'b1;
`endif
        end else begin
          o_q_next = i_q - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with load, tc and a registered wrap pulse; q updates one edge after inputs.
// COUNTER_SAT_EN selects saturating instead of wrapping; clear is async active-high.
module updown_mod_counter #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  updown_mod_counter_if.slave     bus
);
  import counter_pkg::*;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_tc;

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q         (r_q),
    .i_en        (bus.en),
    .i_up_dn     (bus.up_dn),
    .i_load      (bus.load),
    .i_load_val  (bus.load_val),
    .o_q_next    (w_q_next),
    .o_wrap_next (w_wrap_next),
    .o_tc        (w_tc)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.tc   = w_tc;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised scoreboard bench: a MODULUS=10 counter plus a cascaded pair of MODULUS=16 counters.
// Expectations come from an integer modular-arithmetic model of the counter rules.
module tb_updown_mod_counter;

  localparam int M  = 10;
  localparam int MC = 16;

  logic clk;
  logic clr;
  logic chain_clr;

  updown_mod_counter_if #(.WIDTH(4)) bus10 ();
  updown_mod_counter_if #(.WIDTH(4)) bus_lo ();
  updown_mod_counter_if #(.WIDTH(4)) bus_hi ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(M)) dut (
    .clock (clk),
    .clear (clr),
    .bus   (bus10)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(MC)) dut_lo (
    .clock (clk),
    .clear (chain_clr),
    .bus   (bus_lo)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(MC)) dut_hi (
    .clock (clk),
    .clear (chain_clr),
    .bus   (bus_hi)
  );

  assign bus_hi.en = bus_lo.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    int wrap;
    int tc;
    int lo;
    int hi;
    int lo_tc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  int m_q, m_wrap, c_lo, c_hi;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Counting rule for one enabled step of a modulo-m counter.
  function automatic int adv(input int v, input bit up, input int m);
`ifdef COUNTER_SAT_EN
    if (up) return (v + 1 > m - 1) ? m - 1 : v + 1;
    return (v == 0) ? 0 : v - 1;
`else
    if (up) return (v + 1) % m;
    return (v + m - 1) % m;
`endif
  endfunction

  function automatic int wraps(input int v, input bit up, input int m);
`ifdef COUNTER_SAT_EN
    return 0;
`else
    return up ? int'(v + 1 == m) : int'(v == 0);
`endif
  endfunction

  // Drive one cycle of inputs at a falling edge, queue the visible response, advance the model.
  task automatic cycle(input bit en, input bit up, input bit ld, input int lv, input bit cen);
    exp_t e;
    int   lo_tc;
    bus10.en       = en;
    bus10.up_dn    = up;
    bus10.load     = ld;
    bus10.load_val = 4'(lv);
    bus_lo.en      = cen;
    lo_tc          = int'(cen && c_lo == MC - 1);
    e.q     = m_q;
    e.wrap  = m_wrap;
    e.tc    = int'(en && (up ? (m_q == M - 1) : (m_q == 0)));
    e.lo    = c_lo;
    e.hi    = c_hi;
    e.lo_tc = lo_tc;
    sb.push_back(e);
    if (ld) begin
      m_q    = (lv > M - 1) ? M - 1 : lv;
      m_wrap = 0;
    end else if (en) begin
      m_wrap = wraps(m_q, up, M);
      m_q    = adv(m_q, up, M);
    end else begin
      m_wrap = 0;
    end
    if (lo_tc != 0) c_hi = adv(c_hi, 1'b1, MC);
    if (cen) c_lo = adv(c_lo, 1'b1, MC);
    @(negedge clk);
  endtask

  // Hold cycle with clear pulsed between edges; q and wrap must drop before the next edge.
  task automatic do_clear();
    exp_t e;
    bus10.en   = 1'b0;
    bus10.load = 1'b0;
    bus_lo.en  = 1'b0;
    e.q = m_q; e.wrap = m_wrap; e.tc = 0;
    e.lo = c_lo; e.hi = c_hi; e.lo_tc = 0;
    sb.push_back(e);
    m_q    = 0;
    m_wrap = 0;
    #3 clr = 1'b1;
    #1;
    chk("clr_q", bus10.q, 0);
    chk("clr_wrap", bus10.wrap, 0);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", bus10.q, e.q);
        chk("wrap", bus10.wrap, e.wrap);
        chk("tc", bus10.tc, e.tc);
        chk("lo_q", bus_lo.q, e.lo);
        chk("hi_q", bus_hi.q, e.hi);
        chk("lo_tc", bus_lo.tc, e.lo_tc);
      end
    end
  end

  initial begin : stim
    clr            = 1'b1;
    chain_clr      = 1'b1;
    bus10.en       = 1'b0;
    bus10.up_dn    = 1'b1;
    bus10.load     = 1'b0;
    bus10.load_val = '0;
    bus_lo.en      = 1'b0;
    bus_lo.up_dn   = 1'b1;
    bus_lo.load    = 1'b0;
    bus_lo.load_val = '0;
    bus_hi.up_dn   = 1'b1;
    bus_hi.load    = 1'b0;
    bus_hi.load_val = '0;
    m_q = 0; m_wrap = 0; c_lo = 0; c_hi = 0;

    #3;
    chk("rst_q", bus10.q, 0);
    chk("rst_wrap", bus10.wrap, 0);
    chk("rst_tc", bus10.tc, 0);
    chk("rst_lo_q", bus_lo.q, 0);

    @(negedge clk);
    clr       = 1'b0;
    chain_clr = 1'b0;

    // 20 up edges on everything: main counter wraps twice, cascade ends at hi=1 lo=4.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
    #1;
`ifdef COUNTER_SAT_EN
    chk("chain20_lo", bus_lo.q, 15);
    chk("chain20_hi", bus_hi.q, 5);
`else
    chk("chain20_lo", bus_lo.q, 4);
    chk("chain20_hi", bus_hi.q, 1);
`endif

    // Out-of-range load with en set, then an up edge from the clamped top value.
    cycle(1'b1, 1'b1, 1'b1, 12, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Down count through zero.
    cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Reach q=7 and clear mid-cycle.
    cycle(1'b0, 1'b1, 1'b1, 5, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    do_clear();
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Hammer the top value, then reverse direction with no idle cycle.
    cycle(1'b0, 1'b1, 1'b1, 9, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end

    bus10.en  = 1'b0;
    bus10.load = 1'b0;
    bus_lo.en = 1'b0;
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #5;
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
